// File: rtl/ps2_rx_pkg.sv
// Shared types for the PS/2 receiver: FSM state encoding, error-cause codes
// and the frame length helper.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    CHECK = 2'b10
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // start + data + odd parity + stop
  function automatic int frame_bits(input int data_bits);
    return data_bits + 3;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small first-word-fall-through FIFO holding received bytes until the
// consumer pops them. A push into a full FIFO succeeds when a pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: ps2c glitch filter, frame FSM with parity,
// framing and watchdog checks, and an output FIFO. Optional PS2_ERR_CNT_EN adds err_cnt.
module ps2_rx_frame
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk_nexys,
  input  logic                 reset,
  input  logic                 ps2d,
  input  logic                 ps2c,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dato,
  output logic                 empty,
  output logic                 full,
  output logic                 rx_done_tick,
  output logic                 err_tick,
  output logic [1:0]           err_code,
  output logic                 ovf_tick
`ifdef PS2_ERR_CNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS);
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int WD_W       = $clog2(TIMEOUT_CYCLES);

  logic [FILTER_LEN-1:0] filter_q;
  logic                  fclk_q;
  logic                  fclk_d;
  logic                  fall_edge;

  state_e                state_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [CNT_W-1:0]      bitcnt_q;
  logic [WD_W-1:0]       wd_q;
  logic [1:0]            err_code_q;

  logic                  in_check;
  logic                  frame_err;
  logic                  parity_err;
  logic                  good;
  logic                  timeout;
  logic [1:0]            err_code_now;

  // Filtered clock only moves once the whole window agrees
  always_comb begin
    if (filter_q == '1) begin
      fclk_d = 1'b1;
    end else if (filter_q == '0) begin
      fclk_d = 1'b0;
    end else begin
      fclk_d = fclk_q;
    end
  end

  assign fall_edge = fclk_q & ~fclk_d;

  // ps2c glitch filter window and filtered clock
  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) begin
      filter_q <= '0;
      fclk_q   <= 1'b0;
    end else begin
      filter_q <= {ps2c, filter_q[FILTER_LEN-1:1]};
      fclk_q   <= fclk_d;
    end
  end

  assign in_check   = (state_q == CHECK);
  assign frame_err  = frame_q[0] | ~frame_q[FRAME_BITS-1];
  assign parity_err = ~(^frame_q[DATA_BITS+1:1]);
  assign good       = in_check & ~frame_err & ~parity_err;
  assign timeout    = (state_q == SHIFT) & ~fall_edge &
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  assign ovf_tick     = good & full & ~rd_en;
  assign rx_done_tick = good & (~full | rd_en);
  assign err_tick     = timeout | (in_check & (frame_err | parity_err));

  // Framing outranks parity; timeout only arises outside CHECK
  always_comb begin
    if (timeout) begin
      err_code_now = ERR_TIMEOUT;
    end else if (frame_err) begin
      err_code_now = ERR_FRAME;
    end else if (parity_err) begin
      err_code_now = ERR_PARITY;
    end else begin
      err_code_now = ERR_NONE;
    end
  end

  assign err_code = err_tick ? err_code_now : err_code_q;

  // Frame FSM: bit shifting, bit counter, watchdog and held error cause
  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bitcnt_q   <= '0;
      wd_q       <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall_edge) begin
            frame_q  <= {ps2d, frame_q[FRAME_BITS-1:1]};
            bitcnt_q <= CNT_W'(FRAME_BITS - 2);
            wd_q     <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall_edge) begin
            frame_q <= {ps2d, frame_q[FRAME_BITS-1:1]};
            wd_q    <= '0;
            if (bitcnt_q == '0) begin
              state_q <= CHECK;
            end else begin
              bitcnt_q <= bitcnt_q - CNT_W'(1);
            end
          end else if (timeout) begin
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        CHECK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (err_tick) begin
        err_code_q <= err_code_now;
      end
    end
  end

  ps2_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_nexys),
    .rst_ni  (reset),
    .push_i  (rx_done_tick),
    .pop_i   (rd_en),
    .din_i   (frame_q[DATA_BITS:1]),
    .head_o  (dato),
    .empty_o (empty),
    .full_o  (full)
  );

`ifdef PS2_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of rejected and dropped frames
  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= 8'd0;
    end else if ((err_tick | ovf_tick) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good, parity, framing and timeout frames,
// FIFO overflow and simultaneous pop, glitch rejection and mid-frame reset.
module tb_ps2_rx_frame;

  localparam int FILTER_LEN     = 8;
  localparam int DATA_BITS      = 8;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int FIFO_DEPTH     = 4;
  localparam int HALF           = 20;

  logic       clk_nexys = 1'b0;
  logic       reset     = 1'b0;
  logic       ps2d      = 1'b1;
  logic       ps2c      = 1'b1;
  logic       rd_en     = 1'b0;
  logic [7:0] dato;
  logic       empty;
  logic       full;
  logic       rx_done_tick;
  logic       err_tick;
  logic [1:0] err_code;
  logic       ovf_tick;
`ifdef PS2_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_rx     = 0;
  int         n_err    = 0;
  int         n_ovf    = 0;
  logic [1:0] last_code = 2'b00;
  int         rx0;
  int         err0;
  int         ovf0;
  int         first;

  always #5 clk_nexys = ~clk_nexys;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .DATA_BITS      (DATA_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk_nexys    (clk_nexys),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rd_en        (rd_en),
    .dato         (dato),
    .empty        (empty),
    .full         (full),
    .rx_done_tick (rx_done_tick),
    .err_tick     (err_tick),
    .err_code     (err_code),
    .ovf_tick     (ovf_tick)
`ifdef PS2_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  // Tick monitor, sampled mid-cycle after the inputs have settled
  initial begin
    forever begin
      @(negedge clk_nexys);
      #1;
      if (rx_done_tick) n_rx++;
      if (ovf_tick) n_ovf++;
      if (err_tick) begin
        n_err++;
        last_code = err_code;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_nexys);
  endtask

  task automatic snap();
    rx0  = n_rx;
    err0 = n_err;
    ovf0 = n_ovf;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_flip,
                            input logic stop_b, input logic rd_in_check);
    logic [10:0] bits;
    bits = {stop_b, (~^data) ^ par_flip, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2d = bits[i];
      wait_cyc(HALF);
      ps2c = 1'b0;
      if (i == 10 && rd_in_check) begin
        wait_cyc(FILTER_LEN + 1);
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
        wait_cyc(HALF - FILTER_LEN - 2);
      end else begin
        wait_cyc(HALF);
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    wait_cyc(3);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_dato", dato, 0);
    check_eq("rst_rx_done", rx_done_tick, 0);
    check_eq("rst_err_tick", err_tick, 0);
    check_eq("rst_ovf", ovf_tick, 0);
    check_eq("rst_err_code", err_code, 0);
    reset = 1'b1;
    wait_cyc(HALF);

    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_eq("good_rx_cnt", n_rx - rx0, 1);
    check_eq("good_err_cnt", n_err - err0, 0);
    check_eq("good_dato", dato, 8'h1C);
    check_eq("good_empty", empty, 0);
    pop_one();
    check_eq("pop_empty", empty, 1);

    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check_eq("par_err_cnt", n_err - err0, 1);
    check_eq("par_code", last_code, 2'b01);
    check_eq("par_rx_cnt", n_rx - rx0, 0);
    check_eq("par_empty", empty, 1);

    snap();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check_eq("frm_err_cnt", n_err - err0, 1);
    check_eq("frm_code", last_code, 2'b10);
    check_eq("frm_hold_code", err_code, 2'b10);
    check_eq("frm_empty", empty, 1);

    snap();
    for (int i = 0; i < 4; i++) begin
      ps2d = (i == 0) ? 1'b0 : 1'b1;
      wait_cyc(HALF);
      ps2c = 1'b0;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b0;
    wait_cyc(HALF);
    ps2c = 1'b0;
    first = 0;
    for (int c = 1; c <= TIMEOUT_CYCLES + 200 && first == 0; c++) begin
      @(negedge clk_nexys);
      #1;
      if (c == HALF) ps2c = 1'b1;
      if (err_tick) first = c;
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    check_eq("to_latency", first, FILTER_LEN + TIMEOUT_CYCLES);
    wait_cyc(5);
    check_eq("to_err_cnt", n_err - err0, 1);
    check_eq("to_code", last_code, 2'b11);
    check_eq("to_hold_code", err_code, 2'b11);
    check_eq("to_empty", empty, 1);
    wait_cyc(HALF);
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_eq("after_to_rx", n_rx - rx0, 1);
    check_eq("after_to_dato", dato, 8'h5A);
    pop_one();

    snap();
    for (int b = 1; b <= 4; b++) begin
      send_frame(b[7:0], 1'b0, 1'b1, 1'b0);
    end
    check_eq("fill_full", full, 1);
    check_eq("fill_rx", n_rx - rx0, 4);
    send_frame(8'h05, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_cnt", n_ovf - ovf0, 1);
    check_eq("ovf_rx", n_rx - rx0, 4);
    for (int b = 1; b <= 4; b++) begin
      check_eq("ovf_drain", dato, b);
      pop_one();
    end
    check_eq("ovf_drain_empty", empty, 1);

    snap();
    for (int b = 1; b <= 4; b++) begin
      send_frame(b[7:0], 1'b0, 1'b1, 1'b0);
    end
    send_frame(8'h05, 1'b0, 1'b1, 1'b1);
    check_eq("simul_ovf", n_ovf - ovf0, 0);
    check_eq("simul_rx", n_rx - rx0, 5);
    check_eq("simul_full", full, 1);
    for (int b = 2; b <= 5; b++) begin
      check_eq("simul_drain", dato, b);
      pop_one();
    end
    check_eq("simul_empty", empty, 1);

    snap();
    for (int g = 0; g < 5; g++) begin
      ps2c = 1'b0;
      wait_cyc(3);
      ps2c = 1'b1;
      wait_cyc(10);
    end
    wait_cyc(TIMEOUT_CYCLES + 100);
    check_eq("glitch_rx", n_rx - rx0, 0);
    check_eq("glitch_err", n_err - err0, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check_eq("glitch_next_rx", n_rx - rx0, 1);
    check_eq("glitch_next_dato", dato, 8'h3C);
    pop_one();

    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    check_eq("pre_rst_empty", empty, 0);
    for (int i = 0; i < 5; i++) begin
      ps2d = (i == 0) ? 1'b0 : 1'b1;
      wait_cyc(HALF);
      ps2c = 1'b0;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(3);
    check_eq("midrst_empty", empty, 1);
    check_eq("midrst_dato", dato, 0);
    check_eq("midrst_code", err_code, 0);
    reset = 1'b1;
    ps2d  = 1'b1;
    wait_cyc(HALF + 10);
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check_eq("midrst_next_rx", n_rx - rx0, 1);
    check_eq("midrst_next_err", n_err - err0, 0);
    check_eq("midrst_next_dato", dato, 8'hA5);
`ifdef PS2_ERR_CNT_EN
    check_eq("err_cnt_reset", err_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
